// File: rtl/dual_cam_line_sched.sv
// dual_cam_line_sched: drains two per-camera line FIFOs into one merged pixel stream.
// Optional build macro DUAL_SCHED_TESTPAT_EN turns mode 3 into a column/line test pattern.
`default_nettype none

module dual_cam_line_sched #(
    parameter int H_PIX   = 640,
    parameter int H_BLANK = 16,
    parameter int DW      = 16
) (
    input  logic          pclk_i,
    input  logic          sys_rst_i,
    input  logic          cmos_vsync_i,
    input  logic [1:0]    mode_i,
    input  logic          line0_rdy_i,
    input  logic          line1_rdy_i,
    input  logic          fifo0_empty_i,
    input  logic          fifo1_empty_i,
    input  logic [DW-1:0] fifo0_q_i,
    input  logic [DW-1:0] fifo1_q_i,
    output logic          fifo0_rd_en_o,
    output logic          fifo1_rd_en_o,
    output logic          fifo_flush_o,
    output logic          pixel_vsync_o,
    output logic          pixel_href_o,
    output logic [DW-1:0] pixel_data_o,
    output logic [10:0]   line_cnt_o,
    output logic          underflow_o
);

    localparam logic [10:0] C_PIX_LAST   = 11'(H_PIX - 1);
    localparam logic [10:0] C_BLANK_LAST = 11'(H_BLANK - 1);
    localparam logic [10:0] C_CNT_MAX    = 11'd2047;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_RD_A  = 3'd2,
        S_RD_B  = 3'd3,
        S_BLANK = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [10:0] col_q, col_d;
    logic [10:0] line_cnt_q, line_cnt_d;
    logic        und_q, und_d;
    logic        vs1_q, vs2_q;
    logic [1:0]  mode_q;
    logic        flush_q;
    logic        href_q;
    logic        sel_q;
    logic        gap_q;

    logic        w_rise;
    logic        w_fall;
    logic        w_dual;
    logic        w_need0;
    logic        w_need1;
    logic        w_rd0;
    logic        w_rd1;
    logic        w_rd_phase;
    logic        w_sel_d;
    logic        w_gap_d;
    logic [10:0] w_cnt_inc;

    assign w_rise    = cmos_vsync_i & ~vs1_q;
    assign w_fall    = ~cmos_vsync_i & vs1_q;
    // Mode 3 always drains like side-by-side; only its pixel source may differ.
    assign w_dual    = (mode_q == 2'd0) || (mode_q == 2'd3);
    assign w_cnt_inc = (line_cnt_q == C_CNT_MAX) ? line_cnt_q : line_cnt_q + 11'd1;

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        line_cnt_d = line_cnt_q;
        und_d      = und_q;
        w_need0    = 1'b0;
        w_need1    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_fall) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                col_d = 11'd0;
                if (line0_rdy_i && line1_rdy_i) begin
                    state_d = S_RD_A;
                end
            end
            S_RD_A: begin
                w_need1 = 1'b1;
                w_need0 = ~w_dual;
                col_d   = col_q + 11'd1;
                if (col_q == C_PIX_LAST) begin
                    col_d = 11'd0;
                    if (w_dual) begin
                        state_d = S_RD_B;
                    end else begin
                        state_d    = S_BLANK;
                        line_cnt_d = w_cnt_inc;
                    end
                end
            end
            S_RD_B: begin
                w_need0 = 1'b1;
                col_d   = col_q + 11'd1;
                if (col_q == C_PIX_LAST) begin
                    col_d      = 11'd0;
                    state_d    = S_BLANK;
                    line_cnt_d = w_cnt_inc;
                end
            end
            S_BLANK: begin
                col_d = col_q + 11'd1;
                if (col_q == C_BLANK_LAST) begin
                    col_d   = 11'd0;
                    state_d = S_WAIT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Reads are skipped on an empty FIFO, but the column still advances.
        w_rd0 = w_need0 & ~fifo0_empty_i;
        w_rd1 = w_need1 & ~fifo1_empty_i;
        if ((w_need0 && fifo0_empty_i) || (w_need1 && fifo1_empty_i)) begin
            und_d = 1'b1;
        end

        // A new frame start overrides everything, including a coincident line end.
        if (w_rise) begin
            state_d    = S_IDLE;
            col_d      = 11'd0;
            line_cnt_d = 11'd0;
            und_d      = 1'b0;
            w_rd0      = 1'b0;
            w_rd1      = 1'b0;
        end
    end

    assign w_rd_phase = ((state_q == S_RD_A) || (state_q == S_RD_B)) && !w_rise;
    assign w_sel_d    = (state_q == S_RD_A) ? (w_dual ? 1'b1 : (mode_q == 2'd2)) : 1'b0;
    assign w_gap_d    = w_sel_d ? (w_need1 & fifo1_empty_i) : (w_need0 & fifo0_empty_i);

    always_ff @(posedge pclk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            state_q    <= S_IDLE;
            col_q      <= 11'd0;
            line_cnt_q <= 11'd0;
            und_q      <= 1'b0;
            vs1_q      <= 1'b0;
            vs2_q      <= 1'b0;
            mode_q     <= 2'd0;
            flush_q    <= 1'b0;
            href_q     <= 1'b0;
            sel_q      <= 1'b0;
            gap_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            line_cnt_q <= line_cnt_d;
            und_q      <= und_d;
            vs1_q      <= cmos_vsync_i;
            vs2_q      <= vs1_q;
            flush_q    <= w_rise;
            href_q     <= w_rd_phase;
            sel_q      <= w_sel_d;
            gap_q      <= w_gap_d & w_rd_phase;
            if (w_rise) begin
                mode_q <= mode_i;
            end
        end
    end

`ifdef DUAL_SCHED_TESTPAT_EN
    logic [DW-1:0] tp_q;
    logic          tp_en_q;

    always_ff @(posedge pclk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            tp_q    <= '0;
            tp_en_q <= 1'b0;
        end else begin
            tp_q    <= DW'({col_q, line_cnt_q[4:0]});
            tp_en_q <= (mode_q == 2'd3);
        end
    end

    always_comb begin
        pixel_data_o = '0;
        if (href_q && !gap_q) begin
            if (tp_en_q) begin
                pixel_data_o = tp_q;
            end else begin
                pixel_data_o = sel_q ? fifo1_q_i : fifo0_q_i;
            end
        end
    end
`else
    // FIFO data arrives one cycle after the strobe, so the mux sits after href_q.
    always_comb begin
        pixel_data_o = '0;
        if (href_q && !gap_q) begin
            pixel_data_o = sel_q ? fifo1_q_i : fifo0_q_i;
        end
    end
`endif

    assign fifo0_rd_en_o = w_rd0;
    assign fifo1_rd_en_o = w_rd1;
    assign fifo_flush_o  = flush_q;
    assign pixel_vsync_o = vs2_q;
    assign pixel_href_o  = href_q;
    assign line_cnt_o    = line_cnt_q;
    assign underflow_o   = und_q;

endmodule

`default_nettype wire

// File: tb/tb_dual_cam_line_sched.sv
// tb_dual_cam_line_sched: randomized bench with FIFO environment and line-level scoreboard.
`timescale 1ns/1ps
`default_nettype none

module tb_dual_cam_line_sched;

    localparam int H  = 8;
    localparam int HB = 2;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          vsync = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic          rdy0 = 1'b0, rdy1 = 1'b0;
    logic          emp0_r = 1'b1, emp1_r = 1'b1;
    logic          force0 = 1'b0;
    logic          emp0, emp1;
    logic [DW-1:0] q0 = '0, q1 = '0;
    logic          rd0, rd1, flush, pvs, href, und;
    logic [DW-1:0] pdata;
    logic [10:0]   lcnt;

    assign emp0 = emp0_r | force0;
    assign emp1 = emp1_r;

    dual_cam_line_sched #(.H_PIX(H), .H_BLANK(HB), .DW(DW)) dut (
        .pclk_i        (clk),
        .sys_rst_i     (rst),
        .cmos_vsync_i  (vsync),
        .mode_i        (mode),
        .line0_rdy_i   (rdy0),
        .line1_rdy_i   (rdy1),
        .fifo0_empty_i (emp0),
        .fifo1_empty_i (emp1),
        .fifo0_q_i     (q0),
        .fifo1_q_i     (q1),
        .fifo0_rd_en_o (rd0),
        .fifo1_rd_en_o (rd1),
        .fifo_flush_o  (flush),
        .pixel_vsync_o (pvs),
        .pixel_href_o  (href),
        .pixel_data_o  (pdata),
        .line_cnt_o    (lcnt),
        .underflow_o   (und)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // ---------------- FIFO environment ----------------
    logic [DW-1:0] fifo0[$], fifo1[$], ref0[$], ref1[$];
    bit fill_en = 0;
    bit bulk_push = 0;
    int fill_pct = 70;
    int rd0c = 0, rd1c = 0;

    task automatic push0();
        logic [DW-1:0] d;
        d = DW'($urandom);
        fifo0.push_back(d);
        ref0.push_back(d);
    endtask

    task automatic push1();
        logic [DW-1:0] d;
        d = DW'($urandom);
        fifo1.push_back(d);
        ref1.push_back(d);
    endtask

    always @(posedge clk) begin
        if (flush) begin
            fifo0.delete(); fifo1.delete(); ref0.delete(); ref1.delete();
        end else begin
            if (rd0) begin
                q0 <= (fifo0.size() > 0) ? fifo0.pop_front() : 'x;
                rd0c++;
            end
            if (rd1) begin
                q1 <= (fifo1.size() > 0) ? fifo1.pop_front() : 'x;
                rd1c++;
            end
            if (fill_en) begin
                if ($urandom_range(99) < fill_pct && fifo0.size() < 48) push0();
                if ($urandom_range(99) < fill_pct && fifo1.size() < 48) push1();
            end
            if (bulk_push) begin
                for (int i = 0; i < H; i++) begin
                    push0();
                    push1();
                end
                bulk_push = 0;
            end
        end
        rdy0   <= fifo0.size() >= H;
        rdy1   <= fifo1.size() >= H;
        emp0_r <= fifo0.size() == 0;
        emp1_r <= fifo1.size() == 0;
    end

    // ---------------- reference model / scoreboard ----------------
    int  exp_mode  = 0;
    int  lines_exp = 0;
    bit  und_exp   = 0;
    bit  in_line   = 0;
    int  pix = 0, gaps = 0;
    bit  vh1 = 0, vh2 = 0;
    logic [DW-1:0] tp_probe = '0;

    function automatic logic [DW-1:0] pop_ref(input bit cam1);
        if (cam1) return (ref1.size() > 0) ? ref1.pop_front() : 'x;
        return (ref0.size() > 0) ? ref0.pop_front() : 'x;
    endfunction

    always @(posedge clk) begin
        bit dual, src1, gap;
        logic [DW-1:0] e, dump;
        vh2 = vh1;
        vh1 = vsync;
        #1;
        check("pixel_vsync", pvs, vh2);
        dual = (exp_mode == 0) || (exp_mode == 3);
        if (rst) begin
            in_line = 0; lines_exp = 0; und_exp = 0; rd0c = 0; rd1c = 0;
        end else if (flush) begin
            in_line = 0; lines_exp = 0; und_exp = 0; rd0c = 0; rd1c = 0;
        end else if (href) begin
            if (!in_line) begin
                in_line = 1; pix = 0; gaps = 0;
            end
            src1 = dual ? (pix < H) : (exp_mode == 2);
            gap  = !src1 && force0;
            if (gap) begin
                e = '0; gaps++; und_exp = 1;
            end else begin
                e = pop_ref(src1);
            end
            if (!dual) dump = pop_ref(!src1);
`ifdef DUAL_SCHED_TESTPAT_EN
            if (exp_mode == 3 && !gap) e = DW'({11'(pix % H), 5'(lines_exp % 32)});
            if (exp_mode == 3 && lines_exp == 2 && pix == 5) tp_probe = pdata;
`endif
            check("pixel", pdata, e);
            pix++;
        end else if (in_line) begin
            in_line = 0;
            check("href_len", pix, dual ? 2 * H : H);
            lines_exp = (lines_exp >= 2047) ? 2047 : lines_exp + 1;
            check("line_cnt", lcnt, lines_exp);
            check("rd1_cnt", rd1c, H);
            check("rd0_cnt", rd0c, H - gaps);
            check("underflow", und, und_exp);
            rd0c = 0; rd1c = 0;
        end
    end

    // ---------------- stimulus ----------------
    task automatic vs_pulse(input logic [1:0] m);
        @(negedge clk);
        mode = m; vsync = 1'b1; exp_mode = m;
        repeat (3) @(negedge clk);
        vsync = 1'b0;
    endtask

    task automatic wait_lines(input int n, input int budget);
        int k;
        k = 0;
        while (lines_exp < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("line_timeout", lines_exp >= n, 1);
    endtask

    task automatic one_line();
        int tgt;
        tgt = lines_exp + 1;
        repeat (4) @(negedge clk);
        bulk_push = 1;
        wait_lines(tgt, 60);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0;
        repeat (3) @(negedge clk);
        check("rst_href", href, 0);
        check("rst_data", pdata, 0);
        check("rst_flush", flush, 0);
        check("rst_lcnt", lcnt, 0);
        check("rst_und", und, 0);
        check("rst_rd", {rd0, rd1}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_href", href, 0);

        // mode0 latency and layout
        vs_pulse(2'd0);
        repeat (4) @(negedge clk);
        t0 = lines_exp + 1;
        bulk_push = 1;
        @(negedge clk);
        check("wait_rd1", rd1, 0);
        @(negedge clk);
        check("lat_rd1", rd1, 1);
        check("lat_rd0", rd0, 0);
        check("lat_href", href, 0);
        @(negedge clk);
        check("lat_href2", href, 1);
        wait_lines(t0, 60);
        check("m0_lcnt", lcnt, 1);

        // mode1: both strobes together, cam0 data only
        vs_pulse(2'd1);
        repeat (4) @(negedge clk);
        t0 = lines_exp + 1;
        bulk_push = 1;
        repeat (2) @(negedge clk);
        check("m1_rd_both", {rd0, rd1}, 2'b11);
        wait_lines(t0, 60);

        // mode change mid-frame has no effect until next frame
        vs_pulse(2'd0);
        @(negedge clk);
        mode = 2'd2;
        one_line();

        // forced empty on cam0 during the right half
        repeat (4) @(negedge clk);
        t0 = lines_exp + 1;
        bulk_push = 1;
        @(negedge clk);
        repeat (10) @(negedge clk);
        force0 = 1'b1;
        @(negedge clk);
        force0 = 1'b0;
        wait_lines(t0, 60);
        check("und_sticky", und, 1);

        // frame start during RD_A cycle 3 aborts the line
        mode = 2'd0;
        repeat (4) @(negedge clk);
        bulk_push = 1;
        @(negedge clk);
        repeat (3) @(negedge clk);
        check("abort_href_pre", href, 1);
        vsync = 1'b1; exp_mode = 0;
        @(negedge clk);
        check("abort_href", href, 0);
        check("abort_flush", flush, 1);
        check("abort_lcnt", lcnt, 0);
        check("abort_und", und, 0);
        @(negedge clk);
        check("abort_flush_end", flush, 0);
        repeat (2) @(negedge clk);
        vsync = 1'b0;

`ifdef DUAL_SCHED_TESTPAT_EN
        vs_pulse(2'd3);
        repeat (3) one_line();
        check("tp_l2c5", tp_probe, 16'h00A2);
`endif

        // randomized frames
        for (int f = 0; f < 12; f++) begin
            int len;
            vs_pulse(2'($urandom_range(3)));
            fill_en  = 1;
            fill_pct = $urandom_range(40, 100);
            len = $urandom_range(100, 400);
            for (int c = 0; c < len; c++) begin
                @(negedge clk);
                if ($urandom_range(199) == 0) mode = 2'($urandom_range(3));
            end
        end

        // line counter saturation
        vs_pulse(2'd1);
        fill_en = 1; fill_pct = 100;
        wait_lines(2047, 2100 * 14);
        repeat (3 * 14) @(negedge clk);
        check("lcnt_sat", lcnt, 2047);

        // reset mid-line
        t0 = 0;
        while (!href && t0 < 50) begin
            @(negedge clk);
            t0++;
        end
        check("href_before_rst", href, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_href", href, 0);
        check("mid_rst_data", pdata, 0);
        check("mid_rst_lcnt", lcnt, 0);
        check("mid_rst_flush", flush, 0);
        check("mid_rst_rd", {rd0, rd1}, 0);
        repeat (3) @(negedge clk);
        fill_en = 0;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_flush", flush, 0);
        @(negedge clk);
        check("post_rst_flush2", flush, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule

`default_nettype wire
